// File: rtl/keccak_squeeze_ctrl.sv
// Keccak squeeze controller: streams the digest out of the core rate.
// Define KECCAK_OUT_BSWAP_EN to byte-swap each output word.
module keccak_squeeze_ctrl #(
  parameter int D_W   = 11,
  parameter int IDX_W = 6,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       cmode,
  input  logic [D_W-1:0]   d,
  output logic [IDX_W-1:0] rd_idx,
  input  logic [31:0]      core_word_i,
  output logic             squeeze_req,
  input  logic             squeeze_done,
  output logic [31:0]      out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             out_last,
  output logic             busy,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    PRESENT,
    SQUEEZE
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] wcnt;
  logic [CNT_W-1:0] n_words;
  logic [CNT_W-1:0] n_calc;
  logic [CNT_W-1:0] n_shake;
  logic [IDX_W-1:0] rate;
  logic [IDX_W-1:0] rate_calc;
  logic             legal;
  logic             last_word;
  logic             last_idx;
  logic [31:0]      word;

  assign n_shake = CNT_W'((32'(d) + 32'd31) >> 5);

  always_comb begin
    n_calc    = '0;
    rate_calc = '0;
    legal     = 1'b1;
    case (cmode)
      3'd0: begin
        n_calc    = CNT_W'(7);
        rate_calc = IDX_W'(36);
      end
      3'd1: begin
        n_calc    = CNT_W'(8);
        rate_calc = IDX_W'(34);
      end
      3'd2: begin
        n_calc    = CNT_W'(12);
        rate_calc = IDX_W'(26);
      end
      3'd3: begin
        n_calc    = CNT_W'(16);
        rate_calc = IDX_W'(18);
      end
      3'd4: begin
        n_calc    = n_shake;
        rate_calc = IDX_W'(42);
        legal     = (d != '0);
      end
      3'd5: begin
        n_calc    = n_shake;
        rate_calc = IDX_W'(34);
        legal     = (d != '0);
      end
      default: legal = 1'b0;
    endcase
  end

`ifdef KECCAK_OUT_BSWAP_EN
  assign word = {core_word_i[7:0], core_word_i[15:8],
                 core_word_i[23:16], core_word_i[31:24]};
`else
  assign word = core_word_i;
`endif

  assign last_word = (wcnt == n_words - CNT_W'(1));
  assign last_idx  = (rd_idx == rate - IDX_W'(1));

  // rd_idx doubles as the block word index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      wcnt        <= '0;
      n_words     <= '0;
      rate        <= '0;
      rd_idx      <= '0;
      squeeze_req <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      err         <= 1'b0;
    end else begin
      err         <= 1'b0;
      squeeze_req <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (legal) begin
              n_words <= n_calc;
              rate    <= rate_calc;
              wcnt    <= '0;
              rd_idx  <= '0;
              busy    <= 1'b1;
              state   <= FETCH;
            end else begin
              err <= 1'b1;
            end
          end
        end
        FETCH: begin
          out_data  <= word;
          out_valid <= 1'b1;
          out_last  <= last_word;
          state     <= PRESENT;
        end
        PRESENT: begin
          if (out_ready) begin
            wcnt      <= wcnt + CNT_W'(1);
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            if (last_word) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else if (last_idx) begin
              rd_idx      <= '0;
              squeeze_req <= 1'b1;
              state       <= SQUEEZE;
            end else begin
              rd_idx <= rd_idx + IDX_W'(1);
              state  <= FETCH;
            end
          end
        end
        SQUEEZE: begin
          if (squeeze_done) state <= FETCH;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
